fifo_push_arbiter: RTL and testbench



---
 rtl/fifo_push_arbiter_pkg.sv | 12 +
 rtl/fifo_push_arbiter_if.sv | 28 ++
 rtl/fifo_push_arbiter_rr_priority_picker.sv | 34 +++
 rtl/fifo_push_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO push arbiter.
package fifo_push_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_CNT_W = 16;
  localparam logic [STAT_CNT_W-1:0] STAT_CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester-side and FIFO-push-side signals of the push arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface fifo_push_arbiter_if #(
  parameter int unsigned REQ_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned GRANT_W = $clog2(REQ_COUNT);

  logic [REQ_COUNT-1:0]            REQ_VALID;
  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_DATA;
  logic [REQ_COUNT-1:0]            REQ_READY;
  logic                            FIFO_nEN;
  logic [DATA_WIDTH-1:0]           FIFO_DATA;
  logic                            FIFO_FULL;
  logic [GRANT_W-1:0]              GRANT_ID;
  logic                            BUSY;

  modport master (
    output REQ_VALID, REQ_DATA, FIFO_FULL,
    input  REQ_READY, FIFO_nEN, FIFO_DATA, GRANT_ID, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, FIFO_FULL,
    output REQ_READY, FIFO_nEN, FIFO_DATA, GRANT_ID, BUSY
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping past N-1 back to 0.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  logic [IW:0]    sum_c;

  // Rotate so the pointer position lands at bit 0
  assign dbl_c = {req_i, req_i} >> ptr_i;
  assign rot_c = dbl_c[N-1:0];

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum_c   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_o && rot_c[k]) begin
        found_o = 1'b1;
        sum_c   = {1'b0, ptr_i} + (IW+1)'(k);
        idx_o   = (sum_c >= (IW+1)'(N)) ? IW'(sum_c - (IW+1)'(N)) : IW'(sum_c);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among REQ_COUNT requesters.
// Optional per-requester push counters: define FIFO_PUSH_ARBITER_STATS_EN.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int unsigned REQ_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic CLK,
  input  logic RST,
  fifo_push_arbiter_if.slave bus
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  ,
  output logic [REQ_COUNT*STAT_CNT_W-1:0] STAT_PUSH_CNT,
  input  logic                            STAT_CLR
`endif
);

  localparam int unsigned GRANT_W = $clog2(REQ_COUNT);
  localparam int unsigned CNT_W   = $clog2(MAX_BURST + 1);

  arb_state_e           state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   ptr_q;
  logic [CNT_W-1:0]     beat_q;

  logic                 pick_found_c;
  logic [GRANT_W-1:0]   pick_idx_c;
  logic                 burst_c;
  logic                 accept_c;
  logic                 last_beat_c;
  logic [GRANT_W-1:0]   next_ptr_c;
  logic [REQ_COUNT-1:0] ready_c;
  logic [DATA_WIDTH-1:0] slice_c;

  rr_priority_picker #(
    .N  (REQ_COUNT),
    .IW (GRANT_W)
  ) u_picker (
    .req_i   (bus.REQ_VALID),
    .ptr_i   (ptr_q),
    .found_o (pick_found_c),
    .idx_o   (pick_idx_c)
  );

  assign burst_c     = (state_q == ARB_BURST);
  assign accept_c    = burst_c & bus.REQ_VALID[grant_q] & ~bus.FIFO_FULL;
  assign last_beat_c = (beat_q == CNT_W'(MAX_BURST - 1));
  assign next_ptr_c  = (grant_q == GRANT_W'(REQ_COUNT - 1)) ? '0 : grant_q + GRANT_W'(1);
  assign ready_c     = accept_c ? (REQ_COUNT'(1) << grant_q) : '0;

  // Granted requester's data slice
  always_comb begin
    slice_c = '0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (grant_q == GRANT_W'(i)) slice_c = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Push path is combinational so accept and FIFO write share a cycle
  assign bus.REQ_READY = ready_c;
  assign bus.FIFO_nEN  = ~accept_c;
  assign bus.FIFO_DATA = burst_c ? slice_c : '0;
  assign bus.GRANT_ID  = grant_q;
  assign bus.BUSY      = burst_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found_c) begin
            grant_q <= pick_idx_c;
            beat_q  <= '0;
            state_q <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          // Dropping valid releases the grant; full alone only stalls
          if (!bus.REQ_VALID[grant_q] || (accept_c && last_beat_c)) begin
            state_q <= ARB_IDLE;
            ptr_q   <= next_ptr_c;
          end else if (accept_c) begin
            beat_q <= beat_q + CNT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [REQ_COUNT-1:0][STAT_CNT_W-1:0] stat_q;

  // Saturating per-requester push counters; clear beats increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_q <= '0;
    end else if (STAT_CLR) begin
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < REQ_COUNT; i++) begin
        if (ready_c[i] && (stat_q[i] != STAT_CNT_SAT)) stat_q[i] <= stat_q[i] + STAT_CNT_W'(1);
      end
    end
  end

  assign STAT_PUSH_CNT = stat_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed and random checks of fifo_push_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int GW = 2;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  localparam int MB = 255;
`else
  localparam int MB = 4;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  fifo_push_arbiter_if #(.REQ_COUNT(N), .DATA_WIDTH(DW)) bus ();

  logic [N-1:0]         vld  = '0;
  logic                 full = 1'b0;
  logic [N-1:0][DW-1:0] data = '0;

  assign bus.REQ_VALID = vld;
  assign bus.REQ_DATA  = data;
  assign bus.FIFO_FULL = full;

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [N*16-1:0] stat_cnt;
  logic            stat_clr = 1'b0;
  int              m_stat [N];
`endif

  fifo_push_arbiter #(.REQ_COUNT(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    ,
    .STAT_PUSH_CNT (stat_cnt),
    .STAT_CLR      (stat_clr)
`endif
  );

  int errors = 0;
  int checks = 0;
  int pushes = 0;

  // Model: granted or not, whom, beats taken, and who searches first next time
  bit     m_busy;
  int     m_grant;
  int     m_beats;
  int     m_ptr;
  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_beats = 0; m_ptr = 0; last_ready = '0;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) m_stat[i] = 0;
`endif
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1
  task automatic cyc();
    int g;
    int c;
    bit found;
    bit acc;
    logic [GW-1:0] gi;
    logic [N-1:0] er;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    logic [N-1:0][15:0] exp_stat;
`endif
    @(negedge CLK);
    g   = m_grant;
    gi  = GW'(g);
    acc = m_busy && bit_at(vld, g) && !full;
    er  = acc ? (N'(1) << g) : '0;
    check("req_ready", 64'(bus.REQ_READY), 64'(er));
    check("fifo_nen",  64'(bus.FIFO_nEN),  64'(!acc));
    check("grant_id",  64'(bus.GRANT_ID),  64'(g));
    check("busy",      64'(bus.BUSY),      64'(m_busy));
    if (acc) check("fifo_data", 64'(bus.FIFO_DATA), 64'(data[gi]));
    if (bus.FIFO_nEN === 1'b0) pushes++;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) begin
      if (stat_clr) m_stat[i] = 0;
      else if (bit_at(er, i) && m_stat[i] < 65535) m_stat[i]++;
    end
`endif
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && bit_at(vld, c)) begin
          found = 1; m_grant = c; m_beats = 0; m_busy = 1;
        end
      end
    end else if (!bit_at(vld, g)) begin
      m_busy = 0; m_ptr = (g + 1) % N;
    end else if (acc) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0; m_ptr = (g + 1) % N;
      end
    end
    last_ready = er;
    @(posedge CLK);
    #1;
    if (acc) data[gi] = DW'($urandom);
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) exp_stat[i] = 16'(m_stat[i]);
    check("stat_cnt", 64'(stat_cnt), 64'(exp_stat));
`endif
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) data[i] = DW'($urandom);
    model_reset();
    #1 RST = 1'b1;
    #1;
    check("rst_nen",   64'(bus.FIFO_nEN),  64'(1));
    check("rst_ready", 64'(bus.REQ_READY), 64'(0));
    check("rst_grant", 64'(bus.GRANT_ID),  64'(0));
    check("rst_busy",  64'(bus.BUSY),      64'(0));
    check("rst_data",  64'(bus.FIFO_DATA), 64'(0));
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    check("rst_stat",  64'(stat_cnt),      64'(0));
`endif
    @(posedge CLK);
    #1 RST = 1'b0;

    // Single requester: one arbitration cycle per MB beats
    vld = 4'b0001; pushes = 0;
    repeat (2 * (MB + 1)) cyc();
    check("single_rate", 64'(pushes), 64'(2 * MB));
    cyc();
    check("single_regrant", 64'(bus.GRANT_ID), 64'(0));

    // All valid: grants rotate 0,1,2,3,0 with MB pushes each
    reset_dut();
    vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      pushes = 0;
      cyc();
      check("rr_grant", 64'(bus.GRANT_ID), 64'(k % N));
      repeat (MB) cyc();
      check("rr_pushes", 64'(pushes), 64'(MB));
    end

    // Full stalls requester 2 on its second beat for three cycles
    reset_dut();
    vld = 4'b0100; pushes = 0;
    cyc(); cyc();
    full = 1'b1;
    repeat (3) cyc();
    check("stall_grant", 64'(bus.GRANT_ID), 64'(2));
    check("stall_busy",  64'(bus.BUSY),     64'(1));
    check("stall_pushes", 64'(pushes),      64'(1));
    full = 1'b0;
    repeat (MB - 1) cyc();
    check("stall_total", 64'(pushes), 64'(MB));
    vld = '0;
    cyc();

    // Requester 1 releases after two beats; requester 3 is next
    reset_dut();
    vld = 4'b1010; pushes = 0;
    cyc(); cyc(); cyc();
    vld = 4'b1000;
    cyc(); cyc();
    check("release_pushes", 64'(pushes), 64'(2));
    check("release_grant",  64'(bus.GRANT_ID), 64'(3));

    // Asynchronous reset in the middle of a burst
    reset_dut();
    vld = 4'b1111;
    cyc(); cyc(); cyc();
    RST = 1'b1;
    #1;
    check("arst_nen",   64'(bus.FIFO_nEN),  64'(1));
    check("arst_ready", 64'(bus.REQ_READY), 64'(0));
    check("arst_grant", 64'(bus.GRANT_ID),  64'(0));
    check("arst_busy",  64'(bus.BUSY),      64'(0));
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    vld = 4'b1110;
    cyc();
    check("arst_restart", 64'(bus.GRANT_ID), 64'(1));
    vld = 4'b1111;

    // Random traffic honouring the hold-data-until-ready contract
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bit_at(vld, i)) begin
          if (!bit_at(last_ready, i) && $urandom_range(0, 7) == 0) vld = vld & ~(N'(1) << i);
        end else if ($urandom_range(0, 1) == 1) begin
          vld = vld | (N'(1) << i);
          data[i] = DW'($urandom);
        end
      end
      full = ($urandom_range(0, 4) == 0);
      cyc();
    end
    full = 1'b0;

`ifdef FIFO_PUSH_ARBITER_STATS_EN
    // Saturate requester 0's counter, then clear during an accept
    reset_dut();
    vld = 4'b0001;
    for (int c = 0; c < (65540 * (MB + 1)) / MB + 8; c++) cyc();
    check("stat_sat", 64'(stat_cnt[15:0]), 64'(16'hFFFF));
    for (int c = 0; c < MB + 2 && !m_busy; c++) cyc();
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    check("stat_clr", 64'(stat_cnt[15:0]), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
